// File: rtl/event_ram_write.sv
// event_ram_write: write-side sequencer for the LV2 event buffer RAM.
// Captures one framed event into RAM addresses 1..N, publishes N on
// total_number, pulses evt_ready to start the reader, then holds off new
// events until the reader has drained the buffer (rd_busy high then low).
// Optional feature macro: RAM_WR_CHECKSUM_EN appends a modulo-2**DATA_W sum
// of the event words at address N+1 and reports total_number = N+1.
module event_ram_write #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              din_sof,
  input  logic              din_eof,
  input  logic              rd_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] total_number,
  output logic              evt_ready,
  output logic              busy,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ALL1 = '1;
  localparam logic [DROP_W-1:0] DROP_MAX  = '1;
`ifdef RAM_WR_CHECKSUM_EN
  // One address is reserved after the payload for the checksum word.
  localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_ALL1 - ADDR_ONE;
`else
  localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_ALL1;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_DONE    = 3'd2,
`ifdef RAM_WR_CHECKSUM_EN
    S_CKSUM   = 3'd4,
`endif
    S_WAIT_RD = 3'd3
  } state_t;

`ifdef RAM_WR_CHECKSUM_EN
  localparam state_t S_LAST = S_CKSUM;
`else
  localparam state_t S_LAST = S_DONE;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_busy_q;
  logic                wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;
  logic [ADDR_W-1:0]   total_d;
  logic                evt_ready_d;
  logic                overflow_d;
  logic [DROP_W-1:0]   drop_d;
  logic                drop_inc;
  logic                start;
`ifdef RAM_WR_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
`endif

  // Next-state and next-output logic; addr_q always holds the last written address.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    total_d     = total_number;
    evt_ready_d = 1'b0;
    overflow_d  = overflow;
    drop_inc    = 1'b0;
    start       = 1'b0;
`ifdef RAM_WR_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        start = din_valid && din_sof;
      end
      S_CAPTURE: begin
        if (din_valid) begin
          if (din_sof) begin
            // Missing eof: abandon the partial event and restart with this word.
            start    = 1'b1;
            drop_inc = 1'b1;
          end else begin
            if (addr_q == ADDR_MAX) begin
              overflow_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q + ADDR_ONE;
              wr_data_d = din;
              addr_d    = addr_q + ADDR_ONE;
`ifdef RAM_WR_CHECKSUM_EN
              sum_d     = sum_q + din;
`endif
            end
            if (din_eof) begin
              state_d = S_LAST;
            end
          end
        end
      end
`ifdef RAM_WR_CHECKSUM_EN
      S_CKSUM: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q + ADDR_ONE;
        wr_data_d = sum_q;
        addr_d    = addr_q + ADDR_ONE;
        drop_inc  = din_valid && din_sof;
        state_d   = S_DONE;
      end
`endif
      S_DONE: begin
        total_d     = addr_q;
        evt_ready_d = 1'b1;
        drop_inc    = din_valid && din_sof;
        state_d     = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        drop_inc = din_valid && din_sof;
        if (rd_busy_q && !rd_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A start-of-event word always lands at address 1.
    if (start) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = ADDR_ONE;
      wr_data_d  = din;
      addr_d     = ADDR_ONE;
      overflow_d = 1'b0;
`ifdef RAM_WR_CHECKSUM_EN
      sum_d      = din;
`endif
      state_d    = din_eof ? S_LAST : S_CAPTURE;
    end

    drop_d = (drop_inc && (drop_count != DROP_MAX)) ? drop_count + DROP_W'(1) : drop_count;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rd_busy_q    <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      total_number <= '0;
      evt_ready    <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      drop_count   <= '0;
`ifdef RAM_WR_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_busy_q    <= rd_busy;
      wr_en        <= wr_en_d;
      wr_addr      <= wr_addr_d;
      wr_data      <= wr_data_d;
      total_number <= total_d;
      evt_ready    <= evt_ready_d;
      busy         <= (state_d != S_IDLE);
      overflow     <= overflow_d;
      drop_count   <= drop_d;
`ifdef RAM_WR_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_event_ram_write.sv
// tb_event_ram_write: directed vector table plus hand sequences for
// overflow and mid-event reset of event_ram_write (DATA_W=16, ADDR_W=10).
module tb_event_ram_write;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DROP_W = 16;
`ifdef RAM_WR_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] din;
  logic              din_valid, din_sof, din_eof, rd_busy;
  logic              wr_en, evt_ready, busy, overflow;
  logic [ADDR_W-1:0] wr_addr, total_number;
  logic [DATA_W-1:0] wr_data;
  logic [DROP_W-1:0] drop_count;

  event_ram_write #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_sof(din_sof), .din_eof(din_eof), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .total_number(total_number), .evt_ready(evt_ready), .busy(busy),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, sof, eof, rd;
    logic [15:0] din;
    logic        e_wr;
    logic [9:0]  e_addr;
    logic [15:0] e_data;
    logic        e_evt, e_busy, e_ovf;
    logic [9:0]  e_total;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [9:0]  cur_total = '0;
  logic [15:0] cur_drop  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic valid, input logic sof, input logic eof, input logic [15:0] d,
                     input logic rd, input logic e_wr, input logic [9:0] e_addr,
                     input logic [15:0] e_data, input logic e_evt, input logic e_busy);
    vec_t v;
    v.valid = valid; v.sof = sof; v.eof = eof; v.din = d; v.rd = rd;
    v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data; v.e_evt = e_evt;
    v.e_busy = e_busy; v.e_ovf = 1'b0; v.e_total = cur_total; v.e_drop = cur_drop;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic valid, input logic sof, input logic eof,
                       input logic [15:0] d, input logic rd);
    din_valid = valid; din_sof = sof; din_eof = eof; din = d; rd_busy = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Overflow-sequence write tracking.
  int         n_wr = 0;
  int         order_err = 0;
  logic [9:0] last_addr = '0;

  task automatic note_write();
    if (wr_en) begin
      n_wr++;
      if (wr_addr !== last_addr + 10'd1) order_err++;
      last_addr = wr_addr;
    end
  endtask

  initial begin
    vec_t v;
    logic got_evt;

    // Vector table; expected outputs are those seen after the edge that samples each row.
    // Event A: 4 words.
    add(1,1,0,16'h0011,0, 1,10'd1,16'h0011,0,1);
    add(1,0,0,16'h0022,0, 1,10'd2,16'h0022,0,1);
    add(1,0,0,16'h0033,0, 1,10'd3,16'h0033,0,1);
    add(1,0,1,16'h0044,0, 1,10'd4,16'h0044,0,1);
    if (CK != 0) add(0,0,0,16'h0,0, 1,10'd5,16'h00AA,0,1);
    cur_total = 10'(4 + CK);
    add(0,0,0,16'h0,0, 0,10'd0,16'h0,1,1);
    add(0,0,0,16'h0,0, 0,10'd0,16'h0,0,1);
    add(0,0,0,16'h0,1, 0,10'd0,16'h0,0,1);
    add(0,0,0,16'h0,0, 0,10'd0,16'h0,0,0);
    // Word without sof in IDLE is ignored.
    add(1,0,0,16'h1234,0, 0,10'd0,16'h0,0,0);
    // Event B: single word with sof and eof.
    add(1,1,1,16'hBEEF,0, 1,10'd1,16'hBEEF,0,1);
    if (CK != 0) add(0,0,0,16'h0,0, 1,10'd2,16'hBEEF,0,1);
    cur_total = 10'(1 + CK);
    add(0,0,0,16'h0,0, 0,10'd0,16'h0,1,1);
    add(0,0,0,16'h0,1, 0,10'd0,16'h0,0,1);
    // sof while the reader is busy is dropped.
    cur_drop = 16'd1;
    add(1,1,0,16'h5555,1, 0,10'd0,16'h0,0,1);
    add(0,0,0,16'h0,0, 0,10'd0,16'h0,0,0);
    // Event C: 3 words, second sof without eof, then 2 words.
    add(1,1,0,16'h0AAA,0, 1,10'd1,16'h0AAA,0,1);
    add(1,0,0,16'h0BBB,0, 1,10'd2,16'h0BBB,0,1);
    add(1,0,0,16'h0CCC,0, 1,10'd3,16'h0CCC,0,1);
    cur_drop = 16'd2;
    add(1,1,0,16'h0D01,0, 1,10'd1,16'h0D01,0,1);
    add(1,0,1,16'h0D02,0, 1,10'd2,16'h0D02,0,1);
    if (CK != 0) add(0,0,0,16'h0,0, 1,10'd3,16'h1A03,0,1);
    cur_total = 10'(2 + CK);
    add(0,0,0,16'h0,0, 0,10'd0,16'h0,1,1);
    add(0,0,0,16'h0,1, 0,10'd0,16'h0,0,1);
    add(0,0,0,16'h0,0, 0,10'd0,16'h0,0,0);
    // Event D: checksum wrap case 0x0001 + 0x0002 + 0xFFFF = 0x0002.
    add(1,1,0,16'h0001,0, 1,10'd1,16'h0001,0,1);
    add(1,0,0,16'h0002,0, 1,10'd2,16'h0002,0,1);
    add(1,0,1,16'hFFFF,0, 1,10'd3,16'hFFFF,0,1);
    if (CK != 0) add(0,0,0,16'h0,0, 1,10'd4,16'h0002,0,1);
    cur_total = 10'(3 + CK);
    add(0,0,0,16'h0,0, 0,10'd0,16'h0,1,1);
    add(0,0,0,16'h0,1, 0,10'd0,16'h0,0,1);
    add(0,0,0,16'h0,0, 0,10'd0,16'h0,0,0);

    // Reset state.
    reset = 1'b1;
    drive(0,0,0,16'h0,0);
    tick(); tick();
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst evt_ready", 32'(evt_ready), 32'd0);
    chk("rst total", 32'(total_number), 32'd0);
    chk("rst drop", 32'(drop_count), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst wr_addr", 32'(wr_addr), 32'd0);
    reset = 1'b0;
    tick();

    // Apply the table.
    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.valid, v.sof, v.eof, v.din, v.rd);
      tick();
      chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(v.e_wr));
      if (v.e_wr) begin
        chk($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(v.e_addr));
        chk($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(v.e_data));
      end
      chk($sformatf("v%0d evt_ready", i), 32'(evt_ready), 32'(v.e_evt));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(v.e_busy));
      chk($sformatf("v%0d total", i), 32'(total_number), 32'(v.e_total));
      chk($sformatf("v%0d drop", i), 32'(drop_count), 32'(v.e_drop));
      chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(v.e_ovf));
    end

    // Overflow: 1100-word event truncated to 1023 RAM writes.
    drive(1,1,0,16'd1,0);
    tick();
    note_write();
    for (int i = 2; i <= 1100; i++) begin
      drive(1'b1, 1'b0, (i == 1100), 16'(i), 1'b0);
      tick();
      note_write();
    end
    got_evt = 1'b0;
    for (int c = 0; c < 8 && !got_evt; c++) begin
      drive(0,0,0,16'h0,0);
      tick();
      note_write();
      if (evt_ready) got_evt = 1'b1;
    end
    chk("ovf evt_seen", 32'(got_evt), 32'd1);
    chk("ovf n_writes", 32'(n_wr), 32'd1023);
    chk("ovf last_addr", 32'(last_addr), 32'd1023);
    chk("ovf addr_order", 32'(order_err), 32'd0);
    chk("ovf total", 32'(total_number), 32'd1023);
    chk("ovf overflow", 32'(overflow), 32'd1);
    chk("ovf drop", 32'(drop_count), 32'd2);
    drive(0,0,0,16'h0,1); tick();
    drive(0,0,0,16'h0,0); tick();
    chk("ovf drain busy", 32'(busy), 32'd0);
    chk("ovf sticky", 32'(overflow), 32'd1);
    drive(1,1,0,16'h7777,0); tick();
    chk("ovf clear on sof", 32'(overflow), 32'd0);
    chk("ovf new wr_addr", 32'(wr_addr), 32'd1);
    chk("ovf new wr_en", 32'(wr_en), 32'd1);
    drive(1,0,0,16'h8888,0); tick();
    chk("mid wr_addr", 32'(wr_addr), 32'd2);

    // Reset mid-event abandons it.
    reset = 1'b1;
    drive(0,0,0,16'h0,0);
    tick();
    reset = 1'b0;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst wr_en", 32'(wr_en), 32'd0);
    chk("mid rst total", 32'(total_number), 32'd0);
    chk("mid rst drop", 32'(drop_count), 32'd0);
    drive(1,0,1,16'h9999,0); tick();
    chk("post rst eof ignored", 32'(wr_en), 32'd0);
    chk("post rst busy", 32'(busy), 32'd0);
    drive(0,0,0,16'h0,0); tick();
    chk("post rst no evt", 32'(evt_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
